transaction_log_buffer: RTL and testbench
=========================================

TRANSACTION_LOG_BUFFER -- requirements
Module: transaction_log_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, log entry capacity; power of two, 4..64.
REQ-002 SHALL have port mainClock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port eventValid  input  1  one-cycle strobe: a vending transaction completed.
REQ-005 SHALL have port eventMode  input  3  mode code of the completed transaction.
REQ-006 SHALL have port eventProductCode  input  3  product code.
REQ-007 SHALL have port eventCount  input  4  product count.
REQ-008 SHALL have port eventAmount  input  4  money amount (price, charge or receive value).
REQ-009 SHALL have port eventError  input  1  error flag of the transaction.
REQ-010 SHALL have port readReq  input  1  pop one entry.
REQ-011 SHALL have port dumpStart  input  1  strobe: drain the whole log, one entry per cycle.
REQ-012 SHALL have port clearLog  input  1  synchronous flush.
REQ-013 SHALL have port readValid  output  1  readEntry valid this cycle.
REQ-014 SHALL have port readEntry  output  15  {mode[14:12], code[11:9], count[8:5], amount[4:1], error[0]}.
REQ-015 SHALL have port logCount  output  $clog2(DEPTH)+1  number of stored entries.
REQ-016 SHALL have ports full, empty  output  1 each  occupancy flags, registered.
REQ-017 SHALL have port overflow  output  1  sticky: an event arrived while full.
REQ-018 SHALL have port dumping  output  1  high while in DUMP state.

Function
REQ-019 SHALL write on eventValid, packed per REQ-014, at write pointer; entry visible to a read the following cycle.
REQ-020 SHALL NOT log events with eventMode 3'b011 (show-logs); they are ignored entirely.
REQ-021 SHALL, on readReq with !empty in IDLE, register oldest entry onto readEntry and assert readValid the next cycle (latency 1), then pop.
REQ-022 SHALL ignore readReq when empty (readValid stays 0, no pointer change).
REQ-023 SHALL run FSM IDLE->DUMP on dumpStart when !empty; in DUMP pop one entry per cycle with readValid each following cycle; DUMP->IDLE after the entry that empties the log.
REQ-024 SHALL ignore dumpStart when empty or already in DUMP; SHALL ignore readReq during DUMP.
REQ-025 SHALL accept pushes during DUMP; dump ends only when the log is empty.
REQ-026 SHALL, on simultaneous push and pop, perform both; logCount unchanged; when full, the push is accepted.
REQ-027 SHALL wrap read/write pointers modulo DEPTH.
REQ-028 SHALL treat clearLog as highest priority: pointers and logCount to 0, FSM to IDLE, overflow cleared, readValid 0 next cycle, same-cycle push/pop discarded.
REQ-029 SHALL, on push while full with no same-cycle pop, drop the event and set overflow (REQ-034 alters this).

Reset
REQ-030 SHALL on reset assert: readValid=0, readEntry=0, logCount=0, empty=1, full=0, overflow=0, dumping=0, FSM=IDLE, pointers=0.
REQ-031 SHALL abort an in-progress DUMP or read on reset; storage contents need not be cleared.

Configuration
REQ-032 SHALL compile an overwrite mode under macro LOG_OVERWRITE_EN.
REQ-033 SHALL without LOG_OVERWRITE_EN drop events when full per REQ-029.
REQ-034 SHALL with LOG_OVERWRITE_EN, on push while full, discard the oldest entry (advance read pointer), store the new one, keep logCount=DEPTH, and still set overflow.

Structure
REQ-035 SHALL place mode code constants (MODE_BUY..MODE_CHARGE_CUSTOMER), LOG_ENTRY_W=15 and entry field offsets in shared package vending_pkg.
REQ-036 SHALL implement storage as sub-module logMemory (1 write, 1 registered read port, no reset on array).

Verification
REQ-037 SHALL cover: reset, push 3 events (mode 000, code 2, count 1, amount 5, err 0, ...), readReq x3 -> readEntry 15'b000_010_0001_0101_0 first, FIFO order, empty=1 after.
REQ-038 SHALL cover: 17 pushes with DEPTH=16, no macro -> full=1, overflow=1, logCount=16, first entry retained on read.
REQ-039 SHALL cover: same as REQ-038 with LOG_OVERWRITE_EN -> oldest lost, first read returns event #2, logCount=16.
REQ-040 SHALL cover: 5 entries, dumpStart -> readValid high 5 consecutive cycles, dumping falls after last, then readReq gives readValid=0.
REQ-041 SHALL cover: push mode 011 -> logCount unchanged; push+readReq while full -> logCount stays 16, overflow stays 0.
REQ-042 SHALL cover: reset asserted mid-DUMP -> outputs per REQ-030 immediately; clearLog with concurrent eventValid -> logCount=0.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared vending definitions: transaction mode codes, log entry layout and FSM states.
package vending_pkg;

    localparam int unsigned MODE_W   = 3;
    localparam int unsigned CODE_W   = 3;
    localparam int unsigned COUNT_W  = 4;
    localparam int unsigned AMOUNT_W = 4;

    localparam int unsigned LOG_ENTRY_W = 15;
    localparam int unsigned ERROR_LSB   = 0;
    localparam int unsigned AMOUNT_LSB  = 1;
    localparam int unsigned COUNT_LSB   = 5;
    localparam int unsigned CODE_LSB    = 9;
    localparam int unsigned MODE_LSB    = 12;

    localparam logic [MODE_W-1:0] MODE_BUY             = 3'b000;
    localparam logic [MODE_W-1:0] MODE_CHANGE_PRICE    = 3'b001;
    localparam logic [MODE_W-1:0] MODE_RECEIVE         = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHOW_LOGS       = 3'b011;
    localparam logic [MODE_W-1:0] MODE_CHARGE_CUSTOMER = 3'b100;

    typedef enum logic {
        LOG_IDLE = 1'b0,
        LOG_DUMP = 1'b1
    } logState_t;

    function automatic logic [LOG_ENTRY_W-1:0] packEntry(
        input logic [MODE_W-1:0]   mode,
        input logic [CODE_W-1:0]   code,
        input logic [COUNT_W-1:0]  count,
        input logic [AMOUNT_W-1:0] amount,
        input logic                error
    );
        logic [LOG_ENTRY_W-1:0] entry;
        entry = '0;
        entry[MODE_LSB +: MODE_W]     = mode;
        entry[CODE_LSB +: CODE_W]     = code;
        entry[COUNT_LSB +: COUNT_W]   = count;
        entry[AMOUNT_LSB +: AMOUNT_W] = amount;
        entry[ERROR_LSB]              = error;
        return entry;
    endfunction

endpackage

// File: rtl/logMemory.sv
// Log storage: one write port, one registered read port; the array itself has no reset.
module logMemory #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 15
) (
    input  logic                     mainClock,
    input  logic                     reset,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     rdEn,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge mainClock) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Read-before-write: a same-address push and pop returns the old entry.
    always_ff @(posedge mainClock or posedge reset) begin
        if (reset) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/transaction_log_buffer.sv
// Circular transaction log with single pop and full-drain dump mode.
// Optional LOG_OVERWRITE_EN: a push into a full log evicts the oldest entry instead of being dropped.
module transaction_log_buffer
    import vending_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     mainClock,
    input  logic                     reset,
    input  logic                     eventValid,
    input  logic [MODE_W-1:0]        eventMode,
    input  logic [CODE_W-1:0]        eventProductCode,
    input  logic [COUNT_W-1:0]       eventCount,
    input  logic [AMOUNT_W-1:0]      eventAmount,
    input  logic                     eventError,
    input  logic                     readReq,
    input  logic                     dumpStart,
    input  logic                     clearLog,
    output logic                     readValid,
    output logic [LOG_ENTRY_W-1:0]   readEntry,
    output logic [$clog2(DEPTH):0]   logCount,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     dumping
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logState_t        state, stateNext;
    logic [PTR_W-1:0] wrPtr, wrPtrNext, rdPtr, rdPtrNext;
    logic [CNT_W-1:0] countNext;
    logic             overflowNext;
    logic             logReq, pushAccept, popAccept, dropOldest;

    always_ff @(posedge mainClock or posedge reset) begin
        if (reset) begin
            state     <= LOG_IDLE;
            wrPtr     <= '0;
            rdPtr     <= '0;
            logCount  <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            readValid <= 1'b0;
        end else begin
            state     <= stateNext;
            wrPtr     <= wrPtrNext;
            rdPtr     <= rdPtrNext;
            logCount  <= countNext;
            full      <= (countNext == CNT_W'(DEPTH));
            empty     <= (countNext == '0);
            overflow  <= overflowNext;
            readValid <= popAccept;
        end
    end

    // Next-state, pointer and occupancy logic; clearLog overrides everything.
    always_comb begin
        stateNext    = state;
        wrPtrNext    = wrPtr;
        rdPtrNext    = rdPtr;
        countNext    = logCount;
        overflowNext = overflow;
        pushAccept   = 1'b0;
        popAccept    = 1'b0;
        dropOldest   = 1'b0;
        logReq       = eventValid && (eventMode != MODE_SHOW_LOGS);

        if (clearLog) begin
            stateNext    = LOG_IDLE;
            wrPtrNext    = '0;
            rdPtrNext    = '0;
            countNext    = '0;
            overflowNext = 1'b0;
        end else begin
            case (state)
                LOG_IDLE: begin
                    popAccept = readReq && !empty;
                    if (dumpStart && !empty) begin
                        stateNext = LOG_DUMP;
                    end
                end
                LOG_DUMP: popAccept = !empty;
                default:  stateNext = LOG_IDLE;
            endcase

            if (logReq) begin
                if (!full || popAccept) begin
                    pushAccept = 1'b1;
                end else begin
                    overflowNext = 1'b1;
`ifdef LOG_OVERWRITE_EN
                    pushAccept = 1'b1;
                    dropOldest = 1'b1;
`endif
                end
            end

            if (pushAccept) begin
                wrPtrNext = wrPtr + PTR_W'(1);
            end
            if (popAccept || dropOldest) begin
                rdPtrNext = rdPtr + PTR_W'(1);
            end
            if (pushAccept && !popAccept && !dropOldest) begin
                countNext = logCount + CNT_W'(1);
            end else if (popAccept && !pushAccept) begin
                countNext = logCount - CNT_W'(1);
            end

            if (state == LOG_DUMP && countNext == '0) begin
                stateNext = LOG_IDLE;
            end
        end
    end

    assign dumping = (state == LOG_DUMP);

    logMemory #(
        .DEPTH (DEPTH),
        .WIDTH (LOG_ENTRY_W)
    ) u_logMemory (
        .mainClock (mainClock),
        .reset     (reset),
        .wrEn      (pushAccept),
        .wrAddr    (wrPtr),
        .wrData    (packEntry(eventMode, eventProductCode, eventCount, eventAmount, eventError)),
        .rdEn      (popAccept),
        .rdAddr    (rdPtr),
        .rdData    (readEntry)
    );

endmodule

// File: tb/tb_transaction_log_buffer.sv
// Directed self-checking bench for transaction_log_buffer (DEPTH=16); honours LOG_OVERWRITE_EN.
module tb_transaction_log_buffer;

    logic        mainClock = 1'b0;
    logic        reset;
    logic        eventValid;
    logic [2:0]  eventMode;
    logic [2:0]  eventProductCode;
    logic [3:0]  eventCount;
    logic [3:0]  eventAmount;
    logic        eventError;
    logic        readReq;
    logic        dumpStart;
    logic        clearLog;
    logic        readValid;
    logic [14:0] readEntry;
    logic [4:0]  logCount;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        dumping;

    int checks = 0;
    int errors = 0;

    transaction_log_buffer #(.DEPTH(16)) dut (
        .mainClock        (mainClock),
        .reset            (reset),
        .eventValid       (eventValid),
        .eventMode        (eventMode),
        .eventProductCode (eventProductCode),
        .eventCount       (eventCount),
        .eventAmount      (eventAmount),
        .eventError       (eventError),
        .readReq          (readReq),
        .dumpStart        (dumpStart),
        .clearLog         (clearLog),
        .readValid        (readValid),
        .readEntry        (readEntry),
        .logCount         (logCount),
        .full             (full),
        .empty            (empty),
        .overflow         (overflow),
        .dumping          (dumping)
    );

    always #5 mainClock = ~mainClock;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set after a falling edge, outputs sampled at the next falling edge.
    task automatic cyc();
        @(negedge mainClock);
    endtask

    task automatic push(input logic [14:0] e);
        {eventMode, eventProductCode, eventCount, eventAmount, eventError} = e;
        eventValid = 1'b1;
        cyc();
        eventValid = 1'b0;
    endtask

    function automatic logic [14:0] ev(input int i);
        return {3'b001, 3'(i), 4'(i), 4'(15 - i), 1'(i >> 4)};
    endfunction

    localparam logic [14:0] E0 = 15'b000_010_0001_0101_0;
    localparam logic [14:0] E1 = 15'b010_101_0011_1001_1;
    localparam logic [14:0] E2 = 15'b100_111_1111_0000_0;
    localparam logic [14:0] ESHOW = 15'b011_001_0001_0001_0;

    initial begin
        reset = 1'b1;
        {eventValid, eventMode, eventProductCode, eventCount, eventAmount, eventError} = '0;
        {readReq, dumpStart, clearLog} = '0;
        cyc();
        cyc();
        chk("rst_readValid", 32'(readValid), 0);
        chk("rst_readEntry", 32'(readEntry), 0);
        chk("rst_logCount", 32'(logCount), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_dumping", 32'(dumping), 0);
        reset = 1'b0;
        cyc();

        // Basic FIFO order and show-logs filtering
        push(E0);
        chk("push1_count", 32'(logCount), 1);
        chk("push1_empty", 32'(empty), 0);
        push(E1);
        push(E2);
        chk("push3_count", 32'(logCount), 3);
        push(ESHOW);
        chk("showlogs_count", 32'(logCount), 3);
        readReq = 1'b1;
        cyc();
        chk("rd0_valid", 32'(readValid), 1);
        chk("rd0_entry", 32'(readEntry), 32'(E0));
        cyc();
        chk("rd1_entry", 32'(readEntry), 32'(E1));
        cyc();
        chk("rd2_entry", 32'(readEntry), 32'(E2));
        chk("rd2_empty", 32'(empty), 1);
        chk("rd2_count", 32'(logCount), 0);
        cyc();
        chk("rd_empty_valid", 32'(readValid), 0);
        readReq = 1'b0;

        // Fill to capacity, then one more
        for (int i = 0; i < 16; i++) push(ev(i));
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(logCount), 16);
        chk("fill_overflow", 32'(overflow), 0);
        push(ev(16));
        chk("ovf_overflow", 32'(overflow), 1);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_count", 32'(logCount), 16);
        readReq = 1'b1;
        cyc();
        readReq = 1'b0;
        chk("ovf_rd_valid", 32'(readValid), 1);
`ifdef LOG_OVERWRITE_EN
        chk("ovf_rd_entry", 32'(readEntry), 32'(ev(1)));
`else
        chk("ovf_rd_entry", 32'(readEntry), 32'(ev(0)));
`endif
        chk("ovf_rd_count", 32'(logCount), 15);
        chk("ovf_sticky", 32'(overflow), 1);

        // Clear beats a concurrent push and pop
        clearLog = 1'b1;
        readReq = 1'b1;
        eventValid = 1'b1;
        eventMode = 3'b000;
        cyc();
        {clearLog, readReq, eventValid} = '0;
        chk("clr_count", 32'(logCount), 0);
        chk("clr_overflow", 32'(overflow), 0);
        chk("clr_empty", 32'(empty), 1);
        chk("clr_readValid", 32'(readValid), 0);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) push(ev(i + 20));
        {eventMode, eventProductCode, eventCount, eventAmount, eventError} = ev(40);
        eventValid = 1'b1;
        readReq = 1'b1;
        cyc();
        {eventValid, readReq} = '0;
        chk("pp_valid", 32'(readValid), 1);
        chk("pp_entry", 32'(readEntry), 32'(ev(20)));
        chk("pp_count", 32'(logCount), 16);
        chk("pp_full", 32'(full), 1);
        chk("pp_overflow", 32'(overflow), 0);
        clearLog = 1'b1;
        cyc();
        clearLog = 1'b0;

        // Dump five entries
        for (int k = 0; k < 5; k++) push(ev(50 + k));
        dumpStart = 1'b1;
        cyc();
        dumpStart = 1'b0;
        chk("dump_start_dumping", 32'(dumping), 1);
        chk("dump_start_valid", 32'(readValid), 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("dump_valid", 32'(readValid), 1);
            chk("dump_entry", 32'(readEntry), 32'(ev(50 + k)));
            chk("dump_dumping", 32'(dumping), (k < 4) ? 1 : 0);
        end
        chk("dump_empty", 32'(empty), 1);
        readReq = 1'b1;
        cyc();
        readReq = 1'b0;
        chk("post_dump_rd_valid", 32'(readValid), 0);

        // Asynchronous reset in the middle of a dump
        for (int k = 0; k < 3; k++) push(ev(60 + k));
        dumpStart = 1'b1;
        cyc();
        dumpStart = 1'b0;
        cyc();
        chk("mid_dump_valid", 32'(readValid), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_readValid", 32'(readValid), 0);
        chk("arst_readEntry", 32'(readEntry), 0);
        chk("arst_dumping", 32'(dumping), 0);
        chk("arst_count", 32'(logCount), 0);
        chk("arst_empty", 32'(empty), 1);
        cyc();
        reset = 1'b0;
        cyc();
        chk("arst_hold_dumping", 32'(dumping), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
